box_plotter: RTL
================

// Module: box_plotter
// PURPOSE
//  Pixel-generation stage between the keyboard-driven control FSM and vga_adapter (160x120, 3-bit colour).
//  Accepts one "draw box" or "clear screen" request at a time.
//  Emits one pixel per clock as xOut/yOut/colour/plot, which drive vga_adapter x/y/colour/plot directly.
//  Handshake back to control: busy/done.
// PARAMETERS
//  BOX_W      4       box width in pixels (1..16)
//  BOX_H      4       box height in pixels (1..16)
//  SCREEN_W   160     visible columns; x >= SCREEN_W is clipped
//  SCREEN_H   120     visible rows; y >= SCREEN_H is clipped
//  BG_COLOUR  3'b000  colour written by a clear request
// PORTS
//  clock      in   1  system clock (CLOCK_50 domain)
//  reset      in   1  asynchronous, active-high reset
//  draw_req   in   1  request a box draw; sampled only in IDLE
//  clear_req  in   1  request a full-screen clear; sampled only in IDLE
//  x0         in   8  box top-left column; captured with draw_req
//  y0         in   7  box top-left row; captured with draw_req
//  colour_in  in   3  box colour; captured with draw_req
//  busy       out  1  high while pixels are being emitted
//  done       out  1  one-cycle pulse after the last pixel of any request
//  xOut       out  8  pixel column to vga_adapter
//  yOut       out  7  pixel row to vga_adapter
//  colour     out  3  pixel colour to vga_adapter
//  plot       out  1  write enable to vga_adapter
// BEHAVIOUR
//  - Outputs are registered. Reset (async, any state) forces:
//    state=IDLE, busy=0, done=0, plot=0, xOut=0, yOut=0, colour=0.
//    Reset also abandons any partial box; no further pixels are emitted.
//  - FSM states: IDLE, DRAW, CLEAR.
//  - IDLE, edge N samples requests:
//    - clear_req=1 -> CLEAR; clear_req wins over a simultaneous draw_req (draw dropped).
//    - else draw_req=1 -> DRAW; x0/y0/colour_in latched at this edge.
//  - Requests in DRAW/CLEAR are ignored; they are not queued.
//  - Scan order: dx inner (0..BOX_W-1), dy outer. Pixel k is presented after edge N+1+k.
//    - DRAW: BOX_W*BOX_H pixels.
//    - CLEAR: SCREEN_W*SCREEN_H pixels, x 0..159 inner, y 0..119 outer.
//  - DRAW pixel: xOut=x0+dx, yOut=y0+dy; sums computed 9/8 bits wide and truncated on output.
//    - plot=1 only if (x0+dx)<SCREEN_W && (y0+dy)<SCREEN_H; clipped pixels still consume a cycle.
//  - CLEAR pixel: colour=BG_COLOUR, plot=1 every cycle.
//  - busy=1 for exactly the pixel cycles.
//  - The edge after the last pixel: plot=0, busy=0, done=1 for one cycle, state=IDLE.
//    A request may be accepted in that same cycle.
//  - Latency: request at edge N -> first pixel visible after edge N+1.
//    Box completes with done after edge N+1+BOX_W*BOX_H.
//  - Counter wrap: dx resets to 0 and dy increments when dx=BOX_W-1 (or 159 in CLEAR).
//    The request ends when both dx and dy are at their maxima.
// STRUCTURE
//  - Shared include vga_defs.vh: SCREEN_W/H, coordinate widths (8/7), colour width (3), BG_COLOUR.
//    control also uses it.
//  - One sub-module xy_scan_counter, parameterised by limits:
//    - inputs: clock, reset, load, step, x_max, y_max
//    - outputs: dx, dy, last
//    - used for both DRAW and CLEAR by switching the limits.
//  - Top holds the FSM, request latches, offset adders, clip compare and output registers.
// TESTING
//  1. Reset asserted mid-idle and mid-DRAW -> all outputs 0 immediately (async); next edge state=IDLE, no plot.
//  2. draw_req, x0=10, y0=20, colour_in=3'b100 ->
//     16 plot cycles (10,20),(11,20)..(13,23), colour 100; then done=1 for one cycle, busy=0.
//  3. draw_req, x0=158, y0=118 -> busy 16 cycles; plot=1 only at (158..159, 118..119), 4 pulses total.
//  4. clear_req -> 19200 consecutive plot cycles, colour 000; first (0,0), last (159,119); then done pulse.
//  5. draw_req+clear_req same edge -> CLEAR runs; draw_req pulsed during busy -> ignored, no extra box.
//  6. draw_req held high across done cycle -> second box starts on the done edge, gap of 1 non-plot cycle.

Source files
------------

// File: rtl/box_plotter_pkg.sv
// Shared VGA geometry, widths and FSM state type for the box plotter slice.
package box_plotter_pkg;
  localparam int unsigned X_W    = 8;
  localparam int unsigned Y_W    = 7;
  localparam int unsigned COL_W  = 3;
  localparam int unsigned SCR_W  = 160;
  localparam int unsigned SCR_H  = 120;
  localparam logic [COL_W-1:0] BG_DEF = 3'b000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAW  = 2'd1,
    CLEAR = 2'd2
  } state_t;
endpackage

// File: rtl/box_plotter_xy_scan_counter.sv
// Raster scan counter: dx inner, dy outer, with run-time limits so one
// instance serves both box draws and full-screen clears.
module xy_scan_counter
  import box_plotter_pkg::*;
(
  input  logic           clock,
  input  logic           reset,
  input  logic           load,
  input  logic           step,
  input  logic [X_W-1:0] x_max,
  input  logic [Y_W-1:0] y_max,
  output logic [X_W-1:0] dx,
  output logic [Y_W-1:0] dy,
  output logic           last
);
  assign last = (dx == x_max) && (dy == y_max);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dx <= '0;
      dy <= '0;
    end else if (load) begin
      dx <= '0;
      dy <= '0;
    end else if (step) begin
      if (dx == x_max) begin
        dx <= '0;
        dy <= (dy == y_max) ? '0 : dy + 1'b1;
      end else begin
        dx <= dx + 1'b1;
      end
    end
  end
endmodule

// File: rtl/box_plotter.sv
// Pixel generator for vga_adapter: draws a BOX_W x BOX_H box or clears the
// screen, one registered pixel per clock, with busy/done handshake.
module box_plotter
  import box_plotter_pkg::*;
#(
  parameter int unsigned BOX_W    = 4,
  parameter int unsigned BOX_H    = 4,
  parameter int unsigned SCREEN_W = SCR_W,
  parameter int unsigned SCREEN_H = SCR_H,
  parameter logic [COL_W-1:0] BG_COLOUR = BG_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             draw_req,
  input  logic             clear_req,
  input  logic [X_W-1:0]   x0,
  input  logic [Y_W-1:0]   y0,
  input  logic [COL_W-1:0] colour_in,
  output logic             busy,
  output logic             done,
  output logic [X_W-1:0]   xOut,
  output logic [Y_W-1:0]   yOut,
  output logic [COL_W-1:0] colour,
  output logic             plot
);
  localparam logic [X_W-1:0] BOX_XM = X_W'(BOX_W - 1);
  localparam logic [Y_W-1:0] BOX_YM = Y_W'(BOX_H - 1);
  localparam logic [X_W-1:0] CLR_XM = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0] CLR_YM = Y_W'(SCREEN_H - 1);
  localparam logic [X_W:0]   LIM_X  = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0]   LIM_Y  = (Y_W+1)'(SCREEN_H);

  state_t           state_q, state_d;
  logic             fin_q, fin_d;
  logic [X_W-1:0]   x0_q, x0_d;
  logic [Y_W-1:0]   y0_q, y0_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             busy_d, done_d, plot_d;
  logic [X_W-1:0]   x_d;
  logic [Y_W-1:0]   y_d;
  logic [COL_W-1:0] c_d;
  logic             cnt_load, cnt_step, cnt_last;
  logic [X_W-1:0]   x_max, dx;
  logic [Y_W-1:0]   y_max, dy;
  logic [X_W:0]     sx;
  logic [Y_W:0]     sy;

  assign x_max = (state_q == CLEAR) ? CLR_XM : BOX_XM;
  assign y_max = (state_q == CLEAR) ? CLR_YM : BOX_YM;
  assign sx    = {1'b0, x0_q} + {1'b0, dx};
  assign sy    = {1'b0, y0_q} + {1'b0, dy};

  xy_scan_counter u_scan (
    .clock (clock),
    .reset (reset),
    .load  (cnt_load),
    .step  (cnt_step),
    .x_max (x_max),
    .y_max (y_max),
    .dx    (dx),
    .dy    (dy),
    .last  (cnt_last)
  );

  // fin_q marks the cycle after the last pixel: it emits done and also
  // samples requests, so a held request restarts with a one-cycle gap.
  always_comb begin
    state_d  = state_q;
    fin_d    = 1'b0;
    x0_d     = x0_q;
    y0_d     = y0_q;
    col_d    = col_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    plot_d   = 1'b0;
    x_d      = xOut;
    y_d      = yOut;
    c_d      = colour;
    cnt_load = 1'b0;
    cnt_step = 1'b0;
    if (state_q == IDLE || fin_q) begin
      done_d  = fin_q;
      state_d = IDLE;
      if (clear_req) begin
        state_d  = CLEAR;
        cnt_load = 1'b1;
      end else if (draw_req) begin
        state_d  = DRAW;
        cnt_load = 1'b1;
        x0_d     = x0;
        y0_d     = y0;
        col_d    = colour_in;
      end
    end else begin
      busy_d   = 1'b1;
      cnt_step = 1'b1;
      fin_d    = cnt_last;
      if (state_q == CLEAR) begin
        x_d    = dx;
        y_d    = dy;
        c_d    = BG_COLOUR;
        plot_d = 1'b1;
      end else begin
        x_d    = sx[X_W-1:0];
        y_d    = sy[Y_W-1:0];
        c_d    = col_q;
        plot_d = (sx < LIM_X) && (sy < LIM_Y);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      fin_q   <= 1'b0;
      x0_q    <= '0;
      y0_q    <= '0;
      col_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      plot    <= 1'b0;
      xOut    <= '0;
      yOut    <= '0;
      colour  <= '0;
    end else begin
      state_q <= state_d;
      fin_q   <= fin_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      col_q   <= col_d;
      busy    <= busy_d;
      done    <= done_d;
      plot    <= plot_d;
      xOut    <= x_d;
      yOut    <= y_d;
      colour  <= c_d;
    end
  end
endmodule
